// File: rtl/i2c_eeprom_slave.sv
// 24C64-style two-wire EEPROM responder with a host backdoor port.
// SCL/SDA are oversampled on clk; all protocol events are edge-detected from registered copies.
module i2c_eeprom_slave #(
  parameter int         ADDR_W   = 13,
  parameter int         PAGE_W   = 5,
  parameter logic [2:0] DEV_ADDR = 3'b000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              data_in,
  output logic              data_out,
  input  logic [ADDR_W-1:0] host_address,
  input  logic              host_write,
  input  logic [7:0]        host_data_in,
  output logic [7:0]        host_data_out
);

  typedef enum logic [2:0] {IDLE, DEVSEL, ADDR_HI, ADDR_LO, WRITE, READ} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_ce_q;
  logic                r_din_q;
  logic [3:0]          r_bit_cnt;
  logic [7:0]          r_shift;
  logic [7:0]          r_rd;
  logic [ADDR_W-9:0]   r_addr_hi;
  logic [ADDR_W-1:0]   r_ptr;
  logic                r_data_out;
  logic [7:0]          r_host_data_out;
  logic [7:0]          r_mem [2**ADDR_W];

  logic                w_scl_rise;
  logic                w_scl_fall;
  logic                w_start;
  logic                w_stop;
  logic [7:0]          w_byte;
  logic                w_proto_we;
  logic [ADDR_W-1:0]   w_ptr_seq;
  logic [PAGE_W-1:0]   w_ptr_page;

  assign w_scl_rise = !r_ce_q && ce;
  assign w_scl_fall = r_ce_q && !ce;
  assign w_start    = r_ce_q && ce && r_din_q && !data_in;
  assign w_stop     = r_ce_q && ce && !r_din_q && data_in;
  assign w_byte     = {r_shift[6:0], data_in};
  assign w_ptr_seq  = r_ptr + 1'b1;
  assign w_ptr_page = r_ptr[PAGE_W-1:0] + 1'b1;

  assign data_out      = r_data_out;
  assign host_data_out = r_host_data_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    w_state_next = r_state;
    w_proto_we   = 1'b0;
    if (w_start) begin
      w_state_next = DEVSEL;
    end else if (w_stop) begin
      w_state_next = IDLE;
    end else if (w_scl_rise && r_state != IDLE) begin
      if (r_bit_cnt == 4'd7) begin
        if (r_state == DEVSEL && w_byte[7:1] != {4'b1010, DEV_ADDR}) w_state_next = IDLE;
        if (r_state == WRITE) w_proto_we = 1'b1;
      end else if (r_bit_cnt == 4'd8) begin
        case (r_state)
          DEVSEL:  w_state_next = r_shift[0] ? READ : ADDR_HI;
          ADDR_HI: w_state_next = ADDR_LO;
          ADDR_LO: w_state_next = WRITE;
          READ:    if (data_in) w_state_next = IDLE;
          default: w_state_next = r_state;
        endcase
      end
    end
  end

  // Bit counter: 0..7 while a byte is in flight, 8 during the ACK slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ce_q          <= 1'b1;
      r_din_q         <= 1'b1;
      r_bit_cnt       <= 4'd0;
      r_shift         <= 8'h00;
      r_rd            <= 8'h00;
      r_addr_hi       <= '0;
      r_ptr           <= '0;
      r_data_out      <= 1'b1;
      r_host_data_out <= 8'h00;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
      r_ce_q          <= ce;
      r_din_q         <= data_in;
      r_host_data_out <= r_mem[host_address];
      if (w_start || w_stop) begin
        r_bit_cnt  <= 4'd0;
        r_data_out <= 1'b1;
      end else if (r_state != IDLE) begin
        if (w_scl_rise) begin
          if (r_bit_cnt != 4'd8) begin
            r_shift   <= w_byte;
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_state == WRITE && r_bit_cnt == 4'd7)
              r_ptr <= {r_ptr[ADDR_W-1:PAGE_W], w_ptr_page};
          end else begin
            r_bit_cnt <= 4'd0;
            case (r_state)
              DEVSEL:  if (r_shift[0]) r_rd <= r_mem[r_ptr];
              ADDR_HI: r_addr_hi <= r_shift[ADDR_W-9:0];
              ADDR_LO: r_ptr <= {r_addr_hi, r_shift};
              READ: begin
                if (!data_in) begin
                  r_ptr <= w_ptr_seq;
                  r_rd  <= r_mem[w_ptr_seq];
                end
              end
              default: ;
            endcase
          end
        end else if (w_scl_fall) begin
          if (r_bit_cnt == 4'd8) begin
            // Slave ACKs written bytes; in READ the master owns this slot.
            r_data_out <= (r_state == READ);
          end else if (r_state == READ) begin
            r_data_out <= r_rd[7];
            r_rd       <= {r_rd[6:0], 1'b0};
          end else begin
            r_data_out <= 1'b1;
          end
        end
      end
    end
  end

  // NOTE: the array has no reset; save contents must survive a platform reset.
  always_ff @(posedge clk) begin
    if (host_write) r_mem[host_address] <= host_data_in;
    if (w_proto_we && !(host_write && host_address == r_ptr)) r_mem[r_ptr] <= w_byte;
  end

endmodule
